// File: rtl/rf_scoreboard.sv
// Register-file write-back scoreboard: per-GPR pending-write counters that stall ID on RAW/WAW hazards.
// Optional same-cycle WB bypass enabled by defining RF_SCOREBOARD_WB_BYPASS_EN.
module rf_scoreboard #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned NREG  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ds_valid,
   input  logic [4:0] ds_src1,
   input  logic       ds_src1_en,
   input  logic [4:0] ds_src2,
   input  logic       ds_src2_en,
   input  logic [4:0] ds_dest,
   input  logic       ds_rf_we,
   input  logic       es_allow_in,
   output logic       ds_stall,
   output logic       ds_issue,
   input  logic       ws_commit_valid,
   input  logic       ws_rf_we,
   input  logic [4:0] ws_dest,
   input  logic       flush,
   output logic       busy_any,
   output logic       ds_fwd1,
   output logic       ds_fwd2
);

   localparam int unsigned REG_W = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic             busy_any_q;
   logic             busy_any_d;

   logic haz1, haz2, waw_sat, rel, alloc;
   logic fwd1, fwd2, waw_byp;
   logic stall, issue;

   // Hazard detection, optional bypass suppression, and issue decision
   always_comb begin
      haz1    = ds_src1_en && (ds_src1 != '0) && (cnt_q[ds_src1] != '0);
      haz2    = ds_src2_en && (ds_src2 != '0) && (cnt_q[ds_src2] != '0);
      waw_sat = ds_rf_we && (ds_dest != '0) && (cnt_q[ds_dest] == CNT_MAX);
      rel     = ws_commit_valid && ws_rf_we && (ws_dest != '0);
      fwd1    = 1'b0;
      fwd2    = 1'b0;
      waw_byp = 1'b0;
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
      fwd1    = haz1 && (cnt_q[ds_src1] == CNT_ONE) && rel && (ws_dest == ds_src1);
      fwd2    = haz2 && (cnt_q[ds_src2] == CNT_ONE) && rel && (ws_dest == ds_src2);
      waw_byp = waw_sat && rel && (ws_dest == ds_dest);
`endif
      stall = ds_valid && ((haz1 && !fwd1) || (haz2 && !fwd2) || (waw_sat && !waw_byp));
      issue = ds_valid && es_allow_in && !stall && !flush;
      alloc = issue && ds_rf_we && (ds_dest != '0);
   end

   // Counter next state: alloc/release cancel on the same register; flush wipes everything
   always_comb begin
      cnt_d      = cnt_q;
      busy_any_d = 1'b0;
      cnt_d[0]   = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         if (flush) begin
            cnt_d[r] = '0;
         end else if (alloc && (ds_dest == REG_W'(r)) && !(rel && (ws_dest == REG_W'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (rel && (ws_dest == REG_W'(r)) && !(alloc && (ds_dest == REG_W'(r)))
                      && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end
         busy_any_d = busy_any_d | (cnt_d[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
         busy_any_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         busy_any_q <= busy_any_d;
      end
   end

`ifndef SYNTHESIS
   // Releasing a register with no pending write indicates a pipeline protocol bug
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(rel && (cnt_q[ws_dest] == '0)))
            else $error("rf_scoreboard: release of register %0d with no pending write", ws_dest);
      end
   end
`endif

   assign ds_stall = stall;
   assign ds_issue = issue;
   assign ds_fwd1  = ds_valid && fwd1;
   assign ds_fwd2  = ds_valid && fwd2;
   assign busy_any = busy_any_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard; expected values are hand-computed per step.
module tb_rf_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       ds_valid, ds_src1_en, ds_src2_en, ds_rf_we, es_allow_in;
   logic [4:0] ds_src1, ds_src2, ds_dest, ws_dest;
   logic       ds_stall, ds_issue, ws_commit_valid, ws_rf_we, flush, busy_any, ds_fwd1, ds_fwd2;

   int n_assert = 0;
   int n_fail   = 0;

   rf_scoreboard dut (
      .clk(clk), .rst(rst),
      .ds_valid(ds_valid), .ds_src1(ds_src1), .ds_src1_en(ds_src1_en),
      .ds_src2(ds_src2), .ds_src2_en(ds_src2_en), .ds_dest(ds_dest), .ds_rf_we(ds_rf_we),
      .es_allow_in(es_allow_in), .ds_stall(ds_stall), .ds_issue(ds_issue),
      .ws_commit_valid(ws_commit_valid), .ws_rf_we(ws_rf_we), .ws_dest(ws_dest),
      .flush(flush), .busy_any(busy_any), .ds_fwd1(ds_fwd1), .ds_fwd2(ds_fwd2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   // Advance one clock edge, then let inputs change away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic id_idle();
      ds_valid = 0; ds_src1 = 0; ds_src1_en = 0; ds_src2 = 0; ds_src2_en = 0;
      ds_dest = 0; ds_rf_we = 0; es_allow_in = 1;
   endtask

   task automatic ws_idle();
      ws_commit_valid = 0; ws_rf_we = 0; ws_dest = 0;
   endtask

   task automatic id_op(input logic [4:0] s1, input logic s1en, input logic [4:0] d, input logic we);
      ds_valid = 1; ds_src1 = s1; ds_src1_en = s1en; ds_src2 = 0; ds_src2_en = 0;
      ds_dest = d; ds_rf_we = we; es_allow_in = 1;
   endtask

   task automatic commit(input logic [4:0] d);
      ws_commit_valid = 1; ws_rf_we = 1; ws_dest = d;
   endtask

   initial begin
      rst = 1; flush = 0;
      id_idle(); ws_idle();
      step(); step();
      // Reset state
      settle();
      chk("reset_busy", 32'(busy_any), 0);
      chk("reset_stall", 32'(ds_stall), 0);
      chk("reset_issue", 32'(ds_issue), 0);
      chk("reset_cnt6", 32'(dut.cnt_q[6]), 0);
      rst = 0;
      step();

      // Basic issue and allocation
      id_op(5, 1, 6, 1); settle();
      chk("basic_stall", 32'(ds_stall), 0);
      chk("basic_issue", 32'(ds_issue), 1);
      step(); id_idle(); settle();
      chk("basic_cnt6", 32'(dut.cnt_q[6]), 1);
      chk("basic_busy", 32'(busy_any), 1);
      chk("idle_issue", 32'(ds_issue), 0);

      // RAW on r6 released by WB
      id_op(6, 1, 0, 0); settle();
      chk("raw_stall0", 32'(ds_stall), 1);
      chk("raw_issue0", 32'(ds_issue), 0);
      step();
      chk("raw_stall1", 32'(ds_stall), 1);
      commit(6); settle();
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
      chk("raw_byp_stall", 32'(ds_stall), 0);
      chk("raw_byp_issue", 32'(ds_issue), 1);
      chk("raw_byp_fwd1", 32'(ds_fwd1), 1);
      step(); ws_idle(); id_idle(); settle();
`else
      chk("raw_commit_stall", 32'(ds_stall), 1);
      chk("raw_commit_fwd1", 32'(ds_fwd1), 0);
      step(); ws_idle(); settle();
      chk("raw_after_stall", 32'(ds_stall), 0);
      chk("raw_after_issue", 32'(ds_issue), 1);
      step(); id_idle(); settle();
`endif
      chk("raw_cnt6", 32'(dut.cnt_q[6]), 0);
      chk("raw_busy", 32'(busy_any), 0);

      // WAW saturation on r7
      for (int i = 0; i < 3; i++) begin
         id_op(0, 0, 7, 1); settle();
         chk("sat_issue", 32'(ds_issue), 1);
         step();
      end
      settle();
      chk("sat_cnt7", 32'(dut.cnt_q[7]), 3);
      chk("sat_stall", 32'(ds_stall), 1);
      chk("sat_issue4", 32'(ds_issue), 0);
      step();
      commit(7); settle();
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
      chk("sat_byp_issue", 32'(ds_issue), 1);
      step(); ws_idle(); id_idle(); settle();
`else
      chk("sat_commit_stall", 32'(ds_stall), 1);
      step(); ws_idle(); settle();
      chk("sat_cnt7_rel", 32'(dut.cnt_q[7]), 2);
      chk("sat_after_issue", 32'(ds_issue), 1);
      step(); id_idle(); settle();
`endif
      chk("sat_cnt7_back", 32'(dut.cnt_q[7]), 3);
      for (int i = 0; i < 3; i++) begin
         commit(7); step();
      end
      ws_idle(); settle();
      chk("drain_cnt7", 32'(dut.cnt_q[7]), 0);
      chk("drain_busy", 32'(busy_any), 0);

      // Same-cycle alloc/release
      id_op(0, 0, 9, 1); step();
      id_op(0, 0, 10, 1); step();
      id_op(0, 0, 9, 1); commit(9); step();
      ws_idle(); id_idle(); settle();
      chk("same_cnt9", 32'(dut.cnt_q[9]), 1);
      id_op(0, 0, 9, 1); commit(10); step();
      ws_idle(); id_idle(); settle();
      chk("diff_cnt9", 32'(dut.cnt_q[9]), 2);
      chk("diff_cnt10", 32'(dut.cnt_q[10]), 0);
      flush = 1; step(); flush = 0; settle();
      chk("flush1_busy", 32'(busy_any), 0);

      // r0 never tracked
      for (int i = 0; i < 3; i++) begin
         id_op(0, 1, 0, 1); settle();
         chk("r0_stall", 32'(ds_stall), 0);
         step();
      end
      id_idle(); settle();
      chk("r0_cnt0", 32'(dut.cnt_q[0]), 0);
      chk("r0_busy", 32'(busy_any), 0);

      // Flush with a valid issue candidate
      id_op(0, 0, 3, 1); step();
      id_op(0, 0, 4, 1); step();
      id_op(3, 1, 0, 0); settle();
      chk("fl_pre_stall", 32'(ds_stall), 1);
      id_op(0, 0, 5, 1); flush = 1; settle();
      chk("fl_issue", 32'(ds_issue), 0);
      step(); flush = 0; id_idle(); settle();
      chk("fl_cnt3", 32'(dut.cnt_q[3]), 0);
      chk("fl_cnt4", 32'(dut.cnt_q[4]), 0);
      chk("fl_cnt5", 32'(dut.cnt_q[5]), 0);
      chk("fl_busy", 32'(busy_any), 0);
      id_op(3, 1, 0, 0); settle();
      chk("fl_post_stall", 32'(ds_stall), 0);
      chk("fl_post_issue", 32'(ds_issue), 1);
      step(); id_idle();

      // Synchronous reset mid-operation
      id_op(0, 0, 8, 1); step(); id_idle(); settle();
      chk("rst_pre_busy", 32'(busy_any), 1);
      rst = 1; step(); rst = 0; settle();
      chk("rst_cnt8", 32'(dut.cnt_q[8]), 0);
      chk("rst_busy", 32'(busy_any), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Issue scheduler for the register-file write-back path of the 5-stage LoongArch pipeline.
- Tracks in-flight writes to each GPR, from the cycle an instruction is issued out of ID until the cycle WB commits the write.
- Stalls ID on read-after-write and write-after-write hazards against pending writes.
- Releases a register when the WB stage presents a valid write for it.

Parameters:
- CNT_W, 2, width of the per-register pending-write counter. Saturates at 2^CNT_W-1 = 3, which matches the maximum number of in-flight ops in EX/MEM/WB.
- NREG, 32, number of architectural GPRs. Register index width is fixed at 5.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ds_valid  in  1  ID holds a valid instruction
- ds_src1  in  5  source register 1 index
- ds_src1_en  in  1  source 1 is read
- ds_src2  in  5  source register 2 index
- ds_src2_en  in  1  source 2 is read
- ds_dest  in  5  destination register index
- ds_rf_we  in  1  instruction writes ds_dest
- es_allow_in  in  1  EX stage can accept this cycle
- ds_stall  out  1  hazard: ID must hold
- ds_issue  out  1  instruction leaves ID this cycle (allocation strobe)
- ws_commit_valid  in  1  WB stage valid this cycle
- ws_rf_we  in  1  WB instruction writes RF
- ws_dest  in  5  WB destination index
- flush  in  1  kill all in-flight younger ops
- busy_any  out  1  any counter non-zero (registered)
- ds_fwd1  out  1  source 1 takes WB bypass data (BYPASS only, else tied 0)
- ds_fwd2  out  1  source 2 takes WB bypass data (BYPASS only, else tied 0)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset clears all counters to 0 and busy_any to 0. ds_stall, ds_issue, ds_fwd1 and ds_fwd2 are combinational and evaluate to 0 while ds_valid=0.
- Storage: one CNT_W-bit counter per register, cnt[r]. cnt[0] is constant 0; r0 is never allocated, never stalls, never forwards.
- Per-source hazard: hazN = ds_srcN_en && ds_srcN != 0 && cnt[ds_srcN] != 0.
- Write-after-write: ds_rf_we && ds_dest != 0 && cnt[ds_dest] == max. This is the saturation guard; a counter never overflows.
- Stall and issue: ds_stall = ds_valid && (haz1 || haz2 || waw_sat). ds_issue = ds_valid && es_allow_in && !ds_stall && !flush. Both are combinational, with zero-cycle latency.
- Allocation: alloc = ds_issue && ds_rf_we && ds_dest != 0. On alloc, cnt[ds_dest] increments at the next clk edge.
- Release: rel = ws_commit_valid && ws_rf_we && ws_dest != 0. On rel, cnt[ws_dest] decrements at the next clk edge.
- Alloc and release to the same register in the same cycle: the counter is unchanged.
- Alloc and release to different registers in the same cycle: both updates apply.
- Release with cnt=0 is a protocol error. The counter stays 0 (no underflow). Simulation-only assertion fires.
- Stall timing: a release clears a stall the cycle after the commit edge. Without bypass, dependent issue therefore happens one cycle after the WB commit.
- Flush: all counters are cleared to 0 at the next edge. ds_issue is forced to 0 in the flush cycle. Alloc and rel in the flush cycle are ignored. Flush has priority over everything except rst.
- rst asserted mid-operation discards all pending state identically to flush.
- busy_any: registered, equal to the OR of the next-state counters.

Optional Feature:
- Macro: RF_SCOREBOARD_WB_BYPASS_EN.
- When defined: if hazN holds only because cnt[ds_srcN]==1, and rel targets ds_srcN in the same cycle, then hazN is suppressed and ds_fwdN=1. ID then selects the WB final result as operand data. Dependent issue happens in the commit cycle.
- The same rule applies to waw_sat: a same-cycle release of ds_dest at max count permits alloc, and the counter stays at max.
- When undefined: ds_fwd1=ds_fwd2=0 and no suppression.

Test Plan:
- Reset, then ds_valid=1, src1=5 (en), dest=6 (we), es_allow_in=1 -> ds_stall=0, ds_issue=1; cnt[6]=1 next cycle; busy_any=1.
- Issue dest=6, next cycle issue src1=6 -> ds_stall=1 held until the edge after ws_commit_valid=1, ws_rf_we=1, ws_dest=6. Issue follows 1 cycle later. With bypass: issue in the commit cycle with ds_fwd1=1.
- Three back-to-back issues with dest=7, then a fourth dest=7 -> fourth stalls (cnt=3). Commit dest=7 -> fourth issues next cycle; cnt returns to 3.
- Same cycle: alloc dest=9 and commit ws_dest=9 with cnt[9]=1 -> cnt[9] stays 1. Alloc dest=9 with commit dest=10 -> cnt[9]=2, cnt[10] decrements.
- src1=0 with dest=0 repeatedly -> never stalls, cnt unchanged, busy_any=0.
- Counters set for regs 3 and 4, assert flush together with a valid issue -> ds_issue=0; all counters 0 next cycle; busy_any=0; a previously stalled src=3 issues.
